sound_mixer: RTL

//  Time-multiplexed audio mixer feeding the 16-bit DAC serializer (SoundExternal path).
//  On each 48 kHz sample strobe it snapshots CH_COUNT signed channel samples and applies per-channel gain.
//  It then sums the channels, applies master gain and saturates to OUT_WIDTH.
//  A single shared multiplier does the work, so the block runs in the 108 MHz CLK domain.

---
 rtl/sound_pkg.sv | 57 +++++
 rtl/sound_mixer_mac.sv | 90 +++++++++
 rtl/sound_mixer.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/sound_pkg.sv
// Shared definitions for the sound blocks.
//   - mix_state_e : sequencing states of the mixer
//   - sample_t    : signed 16-bit DAC sample
//   - gain_unity(): gain code meaning x1.0 for a given gain width
//   - acc_w()     : accumulator width that cannot overflow for a channel sum
//   - sat_to_out(): clamp a wide signed value to an output width, with clip flag
package sound_pkg;

  localparam int unsigned SAMPLE_W = 16;
  localparam int unsigned SAT_W    = 64;
  localparam logic [7:0]  GAIN_UNITY_8 = 8'h80;

  typedef logic signed [SAMPLE_W-1:0] sample_t;

  typedef enum logic [2:0] {
    StIdle,
    StMac,
    StMaster,
    StSat,
    StOut
  } mix_state_e;

  typedef struct packed {
    logic                    clip;
    logic signed [SAT_W-1:0] val;
  } sat_res_t;

  function automatic int unsigned gain_unity(input int unsigned vol_w);
    return 32'd1 << (vol_w - 1);
  endfunction

  function automatic int unsigned acc_w(input int unsigned in_w, input int unsigned vol_w,
                                        input int unsigned ch_count);
    return in_w + vol_w + 1 + $clog2(ch_count);
  endfunction

  function automatic sat_res_t sat_to_out(input logic signed [SAT_W-1:0] x,
                                          input int unsigned out_w);
    logic signed [SAT_W-1:0] hi;
    logic signed [SAT_W-1:0] lo;
    sat_res_t                r;
    hi = (64'sd1 <<< (out_w - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (x > hi) begin
      r.clip = 1'b1;
      r.val  = hi;
    end else if (x < lo) begin
      r.clip = 1'b1;
      r.val  = lo;
    end else begin
      r.clip = 1'b0;
      r.val  = x;
    end
    return r;
  endfunction

endpackage

// File: rtl/sound_mixer_mac.sv
// Datapath of the mixer: snapshot registers, channel mux, the single shared multiplier and the
// channel accumulator.
// Ports:
//   CLK, RESET   clock, synchronous active-high reset
//   load         capture CH_DATA/CH_VOL/CH_MUTE/MASTER_VOL and clear the accumulator
//   mac_en       add the selected channel's product to the accumulator
//   master_sel   switch multiplier operands to accumulator x master gain
//   ch_idx       channel selected for the multiplier
//   CH_DATA, CH_VOL, CH_MUTE, MASTER_VOL   live inputs (only sampled on load)
//   product      multiplier output (channel term, or acc x master when master_sel)
module sound_mixer_mac
  import sound_pkg::*;
#(
  parameter int unsigned CH_COUNT  = 4,
  parameter int unsigned IN_WIDTH  = 16,
  parameter int unsigned VOL_WIDTH = 8,
  localparam int unsigned ACC_W    = acc_w(IN_WIDTH, VOL_WIDTH, CH_COUNT),
  localparam int unsigned PROD_W   = ACC_W + VOL_WIDTH + 1,
  localparam int unsigned IDX_W    = (CH_COUNT > 1) ? $clog2(CH_COUNT) : 1
) (
  input  logic                          CLK,
  input  logic                          RESET,
  input  logic                          load,
  input  logic                          mac_en,
  input  logic                          master_sel,
  input  logic [IDX_W-1:0]              ch_idx,
  input  logic [CH_COUNT*IN_WIDTH-1:0]  CH_DATA,
  input  logic [CH_COUNT*VOL_WIDTH-1:0] CH_VOL,
  input  logic [CH_COUNT-1:0]           CH_MUTE,
  input  logic [VOL_WIDTH-1:0]          MASTER_VOL,
  output logic signed [PROD_W-1:0]      product
);

  logic [CH_COUNT*IN_WIDTH-1:0]  data_q;
  logic [CH_COUNT*VOL_WIDTH-1:0] vol_q;
  logic [CH_COUNT-1:0]           mute_q;
  logic [VOL_WIDTH-1:0]          master_q;
  logic signed [ACC_W-1:0]       acc_q;

  logic signed [IN_WIDTH-1:0]    data_arr [CH_COUNT];
  logic [VOL_WIDTH-1:0]          vol_arr  [CH_COUNT];

  for (genvar i = 0; i < CH_COUNT; i++) begin : g_unpack
    assign data_arr[i] = data_q[i*IN_WIDTH +: IN_WIDTH];
    assign vol_arr[i]  = vol_q[i*VOL_WIDTH +: VOL_WIDTH];
  end

  logic signed [IN_WIDTH-1:0]  sel_data;
  logic signed [ACC_W-1:0]     op_a;
  logic signed [VOL_WIDTH:0]   op_b;

  always_comb begin
    sel_data = data_arr[ch_idx];
    op_a     = '0;
    op_b     = '0;
    if (master_sel) begin
      op_a = acc_q;
      op_b = $signed({1'b0, master_q});
    end else begin
      // A muted channel feeds zero rather than being skipped, so the cycle count stays fixed.
      if (!mute_q[ch_idx]) begin
        op_a = {{(ACC_W - IN_WIDTH){sel_data[IN_WIDTH-1]}}, sel_data};
      end
      op_b = $signed({1'b0, vol_arr[ch_idx]});
    end
  end

  assign product = $signed({{(PROD_W - ACC_W){op_a[ACC_W-1]}}, op_a}) *
                   $signed({{(PROD_W - VOL_WIDTH - 1){op_b[VOL_WIDTH]}}, op_b});

  always_ff @(posedge CLK) begin
    if (RESET) begin
      data_q   <= '0;
      vol_q    <= '0;
      mute_q   <= '0;
      master_q <= '0;
      acc_q    <= '0;
    end else if (load) begin
      data_q   <= CH_DATA;
      vol_q    <= CH_VOL;
      mute_q   <= CH_MUTE;
      master_q <= MASTER_VOL;
      acc_q    <= '0;
    end else if (mac_en) begin
      // A channel term always fits in ACC_W, so the upper product bits are pure sign.
      acc_q <= acc_q + $signed(product[ACC_W-1:0]);
    end
  end

endmodule

// File: rtl/sound_mixer.sv
// Time-multiplexed audio mixer: per-channel gain, sum, master gain, saturation.
// Optional feature macro: SOUND_MIXER_DC_BLOCK_EN inserts a one-pole DC blocker between the
// master stage and saturation.
// Ports:
//   CLK         system clock
//   RESET       synchronous active-high reset
//   SAMPLE_EN   one-cycle sample strobe
//   CH_DATA     CH_COUNT signed samples, ch0 in LSBs
//   CH_VOL      CH_COUNT unsigned gains (2^(VOL_WIDTH-1) = unity)
//   CH_MUTE     per-channel mute
//   MASTER_VOL  master gain
//   OUT_DATA    mixed signed sample, held between outputs
//   OUT_VALID   one-cycle pulse when OUT_DATA updates
//   CLIP        OUT_DATA was saturated
//   BUSY        a sample is in progress
//   OVERRUN     sticky: strobe arrived while busy
module sound_mixer
  import sound_pkg::*;
#(
  parameter int unsigned CH_COUNT  = 4,
  parameter int unsigned IN_WIDTH  = 16,
  parameter int unsigned VOL_WIDTH = 8,
  parameter int unsigned OUT_WIDTH = 16,
  parameter int unsigned DC_SHIFT  = 10
) (
  input  logic                          CLK,
  input  logic                          RESET,
  input  logic                          SAMPLE_EN,
  input  logic [CH_COUNT*IN_WIDTH-1:0]  CH_DATA,
  input  logic [CH_COUNT*VOL_WIDTH-1:0] CH_VOL,
  input  logic [CH_COUNT-1:0]           CH_MUTE,
  input  logic [VOL_WIDTH-1:0]          MASTER_VOL,
  output logic [OUT_WIDTH-1:0]          OUT_DATA,
  output logic                          OUT_VALID,
  output logic                          CLIP,
  output logic                          BUSY,
  output logic                          OVERRUN
);

  localparam int unsigned ACC_W        = acc_w(IN_WIDTH, VOL_WIDTH, CH_COUNT);
  localparam int unsigned PROD_W       = ACC_W + VOL_WIDTH + 1;
  localparam int unsigned IDX_W        = (CH_COUNT > 1) ? $clog2(CH_COUNT) : 1;
  localparam int unsigned MASTER_SHIFT = 2 * (VOL_WIDTH - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(CH_COUNT - 1);

  mix_state_e               state_q, state_d;
  logic [IDX_W-1:0]         ch_idx_q, ch_idx_d;
  logic                     load, mac_en, master_sel;
  logic signed [PROD_W-1:0] product;
  logic signed [PROD_W-1:0] m_q;

  sound_mixer_mac #(
    .CH_COUNT  (CH_COUNT),
    .IN_WIDTH  (IN_WIDTH),
    .VOL_WIDTH (VOL_WIDTH)
  ) u_mac (
    .CLK        (CLK),
    .RESET      (RESET),
    .load       (load),
    .mac_en     (mac_en),
    .master_sel (master_sel),
    .ch_idx     (ch_idx_q),
    .CH_DATA    (CH_DATA),
    .CH_VOL     (CH_VOL),
    .CH_MUTE    (CH_MUTE),
    .MASTER_VOL (MASTER_VOL),
    .product    (product)
  );

  // Sequencing
  always_comb begin
    state_d    = state_q;
    ch_idx_d   = ch_idx_q;
    load       = 1'b0;
    mac_en     = 1'b0;
    master_sel = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (SAMPLE_EN) begin
          load     = 1'b1;
          ch_idx_d = '0;
          state_d  = StMac;
        end
      end
      StMac: begin
        mac_en = 1'b1;
        if (ch_idx_q == LAST_IDX) begin
          state_d = StMaster;
        end else begin
          ch_idx_d = ch_idx_q + 1'b1;
        end
      end
      StMaster: begin
        master_sel = 1'b1;
        state_d    = StSat;
      end
      StSat:   state_d = StOut;
      StOut:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Saturation input: either m directly or the DC-blocked m
  logic signed [SAT_W-1:0] sat_in;
  sat_res_t                sat_r;

`ifdef SOUND_MIXER_DC_BLOCK_EN
  localparam int unsigned DC_W = ACC_W + VOL_WIDTH + 2;

  logic signed [DC_W-1:0] x_prev_q, y_prev_q;
  logic signed [DC_W-1:0] m_ext, y_d;

  assign m_ext  = {{(DC_W - PROD_W){m_q[PROD_W-1]}}, m_q};
  // m_q and the history are stable through SAT and OUT, so y_d is the same value in both.
  assign y_d    = m_ext - x_prev_q + y_prev_q - (y_prev_q >>> DC_SHIFT);
  assign sat_in = {{(SAT_W - DC_W){y_d[DC_W-1]}}, y_d};

  always_ff @(posedge CLK) begin
    if (RESET) begin
      x_prev_q <= '0;
      y_prev_q <= '0;
    end else if (state_q == StOut) begin
      x_prev_q <= m_ext;
      y_prev_q <= y_d;
    end
  end
`else
  assign sat_in = {{(SAT_W - PROD_W){m_q[PROD_W-1]}}, m_q};

  logic unused_dc_shift;
  assign unused_dc_shift = ^DC_SHIFT;
`endif

  always_comb begin
    sat_r = sat_to_out(sat_in, OUT_WIDTH);
  end

  logic unused_sat_hi;
  assign unused_sat_hi = ^sat_r.val[SAT_W-1:OUT_WIDTH];

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q  <= StIdle;
      ch_idx_q <= '0;
      m_q      <= '0;
      OUT_DATA <= '0;
      CLIP     <= 1'b0;
      OVERRUN  <= 1'b0;
    end else begin
      state_q  <= state_d;
      ch_idx_q <= ch_idx_d;
      if (state_q == StMaster) begin
        // Arithmetic shift: floor rounding, and exact zero when either gain is zero.
        m_q <= product >>> MASTER_SHIFT;
      end
      // Registered on the SAT->OUT edge so OUT_DATA/CLIP change together with OUT_VALID.
      if (state_q == StSat) begin
        OUT_DATA <= sat_r.val[OUT_WIDTH-1:0];
        CLIP     <= sat_r.clip;
      end
      if (SAMPLE_EN && (state_q != StIdle)) begin
        OVERRUN <= 1'b1;
      end
    end
  end

  assign OUT_VALID = (state_q == StOut);
  assign BUSY      = (state_q != StIdle);

endmodule
